game_score_sprite: RTL and testbench
====================================

// Module: game_score_sprite
//
// PURPOSE
//  Producer side of the mixer's score sprite inputs. Keeps a 3-digit BCD game score, and from the
//  current pixel coordinate generates three sprite streams (rgb_en + rgb), one per digit, which
//  feed the mixer's score_1/2/3 inputs. Displayed digits are snapshotted at frame start (no tearing).
//  After each displayed change, all three digits use a highlight colour for a number of frames.
//
// PARAMETERS
//  X_WIDTH        10      pixel_x width
//  Y_WIDTH        10      pixel_y width
//  X0             16      left x of hundreds digit cell
//  Y0             16      top y of digit cells
//  SCALE_LOG2     2       glyph unit = 2**SCALE_LOG2 pixels, range 0..3
//  COLOR          3'b010  normal digit colour
//  HILITE_COLOR   3'b110  highlight colour
//  HILITE_FRAMES  30      frames of highlight after a displayed change, 1..255
//  BLANK_LEADING  1       1: suppress leading zeros (units digit never blanked)
//
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous reset, active-high
//  pixel_x       in   X_WIDTH           current pixel column
//  pixel_y       in   Y_WIDTH           current pixel row
//  frame_start   in   1                 1-cycle pulse at start of each frame
//  score_inc     in   1                 1-cycle pulse: score + 1
//  score_clear   in   1                 1-cycle pulse: score := 0
//  score         out  12                live BCD score {hundreds, tens, units}
//  score_sat     out  1                 1 while score == 999
//  score_1_rgb_en  out 1                hundreds digit pixel on
//  score_1_rgb   out  `GAME_RGB_WIDTH   hundreds digit colour
//  score_2_rgb_en  out 1                tens digit pixel on
//  score_2_rgb   out  `GAME_RGB_WIDTH   tens digit colour
//  score_3_rgb_en  out 1                units digit pixel on
//  score_3_rgb   out  `GAME_RGB_WIDTH   units digit colour
//
// BEHAVIOUR
//  Reset: score=0, shadow=0, hilite_cnt=0, all rgb_en=0, all rgb=0, score_sat=0.
//  Score counter (updates on the clock edge after the pulse):
//   - score_clear has priority over score_inc in the same cycle -> score=0.
//   - score_inc: BCD increment, units 9->0 carries to tens, tens 9->0 carries to hundreds.
//   - at 999, score_inc ignored (saturates); score_sat = (score==999), registered with score.
//  Shadow / highlight (on frame_start only):
//   - shadow <= score. If new value != old shadow: hilite_cnt <= HILITE_FRAMES.
//   - else if hilite_cnt != 0: hilite_cnt <= hilite_cnt - 1.
//   - score changes between frame_starts never affect the displayed image.
//   - frame_start and score_inc same cycle: shadow takes pre-increment score.
//  Geometry (U = 2**SCALE_LOG2): digit i (0=hundreds,1=tens,2=units) cell x in
//   [X0+i*4U, X0+i*4U+3U), y in [Y0, Y0+5U). Glyph 3x5 units; col=(x-cell_x)>>SCALE_LOG2,
//   row=(y-Y0)>>SCALE_LOG2. 1-unit gap between digits. Compare without wrap (widen before add).
//  Font: fixed 3x5 ROM for 0..9; BCD codes 10..15 never occur; decode as blank.
//  Output (latency exactly 1 cycle from pixel_x/pixel_y):
//   - score_k_rgb_en <= inside cell k && font bit set && digit k not blanked.
//   - score_k_rgb <= (hilite_cnt!=0 ? HILITE_COLOR : COLOR) when en, else 0.
//   - Blanking (BLANK_LEADING=1): hundreds blank if shadow hundreds==0; tens blank if
//     hundreds==0 && tens==0; units never blank. BLANK_LEADING=0: no blanking.
//   - Digit cells never overlap: at most one rgb_en high per cycle.
//  Reset mid-frame: outputs go to 0 on the reset edge; display shows "0" from next frame_start.
//
// TESTING
//  1) reset, frame_start, scan cell 2 -> only score_3 pixels of glyph "0", COLOR; score_1/2_en stay 0.
//  2) 9 score_inc then 1 more -> score 12'h009 then 12'h010 (carry); after frame_start tens "1" visible.
//  3) 1005 score_inc -> score 12'h999, score_sat=1, further pulses leave 12'h999.
//  4) score_inc and score_clear same cycle at score 12'h042 -> score 12'h000.
//  5) change then frame_start -> rgb=HILITE_COLOR for HILITE_FRAMES frames, then COLOR at next frame.
//  6) pixel at (X0,Y0) for score 12'h100 -> score_1_rgb_en=1 exactly 1 cycle later; score inc mid-frame
//     -> image unchanged until frame_start.

Source files
------------

// File: rtl/game_score_sprite.sv
// -----------------------------------------------------------------------------
// game_score_sprite
//
// Keeps a 3-digit BCD game score and renders it as three sprite streams
// (one per digit) for the mixer's score_1/2/3 inputs. The digits shown on
// screen come from a shadow copy taken at frame start, so a score change
// in the middle of a frame never tears the image. After a displayed change,
// all digits use HILITE_COLOR for HILITE_FRAMES frames.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pixel_x, pixel_y  current pixel coordinate (output latency: 1 cycle)
//   frame_start       1-cycle pulse at start of each frame (shadow capture)
//   score_inc         1-cycle pulse: BCD increment, saturating at 999
//   score_clear       1-cycle pulse: score := 0 (wins over score_inc)
//   score             live BCD score {hundreds, tens, units}
//   score_sat         1 while score == 999
//   score_k_rgb_en    digit k pixel on (1=hundreds, 2=tens, 3=units)
//   score_k_rgb       digit k colour, 0 when the pixel is off
// -----------------------------------------------------------------------------
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif

module game_score_sprite #(
    parameter int                          X_WIDTH       = 10,
    parameter int                          Y_WIDTH       = 10,
    parameter int                          X0            = 16,
    parameter int                          Y0            = 16,
    parameter int                          SCALE_LOG2    = 2,
    parameter logic [`GAME_RGB_WIDTH-1:0]  COLOR         = 3'b010,
    parameter logic [`GAME_RGB_WIDTH-1:0]  HILITE_COLOR  = 3'b110,
    parameter int                          HILITE_FRAMES = 30,
    parameter int                          BLANK_LEADING = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [X_WIDTH-1:0]          pixel_x,
    input  logic [Y_WIDTH-1:0]          pixel_y,
    input  logic                        frame_start,
    input  logic                        score_inc,
    input  logic                        score_clear,
    output logic [11:0]                 score,
    output logic                        score_sat,
    output logic                        score_1_rgb_en,
    output logic [`GAME_RGB_WIDTH-1:0]  score_1_rgb,
    output logic                        score_2_rgb_en,
    output logic [`GAME_RGB_WIDTH-1:0]  score_2_rgb,
    output logic                        score_3_rgb_en,
    output logic [`GAME_RGB_WIDTH-1:0]  score_3_rgb
);

    localparam int RGB_W = `GAME_RGB_WIDTH;
    localparam int U     = 1 << SCALE_LOG2;

    // Geometry is evaluated in 32 bits so cell edges near the top of the
    // pixel range cannot wrap.
    localparam logic [31:0] CELL_W = 32'(3 * U);
    localparam logic [31:0] CELL_H = 32'(5 * U);
    localparam logic [31:0] PITCH  = 32'(4 * U);
    localparam logic [31:0] X0_W   = 32'(X0);
    localparam logic [31:0] Y0_W   = 32'(Y0);

    // 3x5 glyphs, row 0 first, leftmost column is the MSB of each row.
    function automatic logic font_bit(input logic [3:0] d,
                                      input logic [2:0] row,
                                      input logic [1:0] col);
        logic [14:0] g;
        case (d)
            4'd0:    g = 15'b111_101_101_101_111;
            4'd1:    g = 15'b110_010_010_010_111;
            4'd2:    g = 15'b111_001_111_100_111;
            4'd3:    g = 15'b111_001_111_001_111;
            4'd4:    g = 15'b101_101_111_001_001;
            4'd5:    g = 15'b111_100_111_001_111;
            4'd6:    g = 15'b111_100_111_101_111;
            4'd7:    g = 15'b111_001_001_001_001;
            4'd8:    g = 15'b111_101_111_101_111;
            4'd9:    g = 15'b111_101_111_001_111;
            default: g = 15'b0;  // codes 10..15 render blank
        endcase
        if (row > 3'd4 || col > 2'd2) begin
            return 1'b0;
        end
        return g[4'd14 - 4'(row) * 4'd3 - 4'(col)];
    endfunction

    logic [11:0]            score_q,      score_d;
    logic                   score_sat_q,  score_sat_d;
    logic [11:0]            shadow_q,     shadow_d;
    logic [7:0]             hilite_cnt_q, hilite_cnt_d;
    logic [2:0]             en_q,         en_d;
    logic [2:0][RGB_W-1:0]  rgb_q,        rgb_d;

    // Score counter: clear wins, increment saturates at 999.
    always_comb begin
        score_d = score_q;
        if (score_clear) begin
            score_d = 12'h000;
        end else if (score_inc && score_q != 12'h999) begin
            if (score_q[3:0] != 4'd9) begin
                score_d[3:0] = score_q[3:0] + 4'd1;
            end else begin
                score_d[3:0] = 4'd0;
                if (score_q[7:4] != 4'd9) begin
                    score_d[7:4] = score_q[7:4] + 4'd1;
                end else begin
                    score_d[7:4]  = 4'd0;
                    score_d[11:8] = score_q[11:8] + 4'd1;
                end
            end
        end
        score_sat_d = (score_d == 12'h999);
    end

    // Shadow capture: takes the pre-update score, so an increment in the
    // same cycle as frame_start shows up one frame later.
    always_comb begin
        shadow_d     = shadow_q;
        hilite_cnt_d = hilite_cnt_q;
        if (frame_start) begin
            shadow_d = score_q;
            if (score_q != shadow_q) begin
                hilite_cnt_d = 8'(HILITE_FRAMES);
            end else if (hilite_cnt_q != 8'd0) begin
                hilite_cnt_d = hilite_cnt_q - 8'd1;
            end
        end
    end

    // Pixel stage: cell hit, glyph lookup and leading-zero blanking.
    logic [31:0]      px_w, py_w, cell_x;
    logic             in_rows, in_cell, lit;
    logic [2:0]       row;
    logic [1:0]       col;
    logic [3:0]       digit;
    logic [2:0]       blank;
    logic [RGB_W-1:0] color;

    always_comb begin
        px_w     = 32'(pixel_x);
        py_w     = 32'(pixel_y);
        cell_x   = X0_W;
        in_cell  = 1'b0;
        lit      = 1'b0;
        col      = 2'd0;
        digit    = 4'd0;
        en_d     = '0;
        rgb_d    = '0;
        in_rows  = (py_w >= Y0_W) && (py_w < Y0_W + CELL_H);
        row      = 3'((py_w - Y0_W) >> SCALE_LOG2);
        color    = (hilite_cnt_q != 8'd0) ? HILITE_COLOR : COLOR;
        blank[0] = (BLANK_LEADING != 0) && (shadow_q[11:8] == 4'd0);
        blank[1] = (BLANK_LEADING != 0) && (shadow_q[11:4] == 8'd0);
        blank[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cell_x   = X0_W + PITCH * 32'(i);
            in_cell  = in_rows && (px_w >= cell_x) && (px_w < cell_x + CELL_W);
            col      = 2'((px_w - cell_x) >> SCALE_LOG2);
            digit    = shadow_q[4*(2-i) +: 4];
            lit      = font_bit(digit, row, col);
            en_d[i]  = in_cell && lit && !blank[i];
            rgb_d[i] = en_d[i] ? color : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q      <= 12'h000;
            score_sat_q  <= 1'b0;
            shadow_q     <= 12'h000;
            hilite_cnt_q <= 8'd0;
            en_q         <= '0;
            rgb_q        <= '0;
        end else begin
            score_q      <= score_d;
            score_sat_q  <= score_sat_d;
            shadow_q     <= shadow_d;
            hilite_cnt_q <= hilite_cnt_d;
            en_q         <= en_d;
            rgb_q        <= rgb_d;
        end
    end

    assign score          = score_q;
    assign score_sat      = score_sat_q;
    assign score_1_rgb_en = en_q[0];
    assign score_1_rgb    = rgb_q[0];
    assign score_2_rgb_en = en_q[1];
    assign score_2_rgb    = rgb_q[1];
    assign score_3_rgb_en = en_q[2];
    assign score_3_rgb    = rgb_q[2];

endmodule

// File: tb/tb_game_score_sprite.sv
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif

module tb_game_score_sprite;

    localparam logic [2:0] NORM_C = 3'b010;
    localparam logic [2:0] HI_C   = 3'b110;
    localparam int         HF     = 30;

    // Reference font, one row per 3 characters, row 0 first.
    localparam logic [14:0] FONT [10] = '{
        15'b111_101_101_101_111, 15'b110_010_010_010_111,
        15'b111_001_111_100_111, 15'b111_001_111_001_111,
        15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001,
        15'b111_101_111_101_111, 15'b111_101_111_001_111};

    logic        clk = 1'b0;
    logic        rst, frame_start, score_inc, score_clear;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] score;
    logic        score_sat;
    logic        score_1_rgb_en, score_2_rgb_en, score_3_rgb_en;
    logic [2:0]  score_1_rgb, score_2_rgb, score_3_rgb;
    logic [11:0] obs_pix;

    assign obs_pix = {score_1_rgb_en, score_1_rgb, score_2_rgb_en, score_2_rgb,
                      score_3_rgb_en, score_3_rgb};

    game_score_sprite dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .score_inc(score_inc), .score_clear(score_clear),
        .score(score), .score_sat(score_sat),
        .score_1_rgb_en(score_1_rgb_en), .score_1_rgb(score_1_rgb),
        .score_2_rgb_en(score_2_rgb_en), .score_2_rgb(score_2_rgb),
        .score_3_rgb_en(score_3_rgb_en), .score_3_rgb(score_3_rgb));

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          m_score = 0, m_shadow = 0, m_hcnt = 0;
    logic [11:0] exp_pix;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected {en1,rgb1,en2,rgb2,en3,rgb3} for a pixel, from the displayed value.
    function automatic logic [11:0] model_pix(input int x, input int y);
        logic [11:0] r;
        logic [14:0] g;
        int digs[3];
        int cx, col, row;
        bit blank;
        r = '0;
        digs[0] = m_shadow / 100;
        digs[1] = (m_shadow / 10) % 10;
        digs[2] = m_shadow % 10;
        for (int d = 0; d < 3; d++) begin
            cx = 16 + 16 * d;
            if (x >= cx && x < cx + 12 && y >= 16 && y < 36) begin
                col   = (x - cx) / 4;
                row   = (y - 16) / 4;
                blank = (d == 0 && m_shadow < 100) || (d == 1 && m_shadow < 10);
                g     = FONT[digs[d]];
                if (!blank && g[14 - (row * 3 + col)])
                    r[11 - 4*d -: 4] = {1'b1, (m_hcnt != 0) ? HI_C : NORM_C};
            end
        end
        return r;
    endfunction

    // One clock: drive inputs, advance model at the edge, return 1 unit later.
    task automatic step(input bit fs, input bit inc, input bit clr, input bit r,
                        input int x, input int y);
        logic [11:0] pre;
        rst = r; frame_start = fs; score_inc = inc; score_clear = clr;
        pixel_x = 10'(x); pixel_y = 10'(y);
        pre = r ? 12'h000 : model_pix(x, y);
        @(posedge clk);
        if (r) begin
            m_score = 0; m_shadow = 0; m_hcnt = 0;
        end else begin
            if (fs) begin
                if (m_score != m_shadow) m_hcnt = HF;
                else if (m_hcnt != 0) m_hcnt = m_hcnt - 1;
                m_shadow = m_score;
            end
            if (clr) m_score = 0;
            else if (inc && m_score < 999) m_score = m_score + 1;
        end
        exp_pix = pre;
        #1;
        frame_start = 1'b0; score_inc = 1'b0; score_clear = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        int cnt3;
        step(1'b1, 1'b1, 1'b0, 1'b1, 20, 20);
        checks++;
        if (score !== 12'h000) begin failures++; $display("FAIL reset_score got=%h exp=000", score); end
        checks++;
        if (score_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", score_sat); end
        checks++;
        if (obs_pix !== 12'h000) begin failures++; $display("FAIL reset_pix got=%h exp=000", obs_pix); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cnt3 = 0;
        for (int y = 14; y < 38; y++) begin
            for (int x = 44; x < 64; x++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, x, y);
                checks++;
                if (obs_pix !== exp_pix) begin
                    failures++; $display("FAIL scan0 (%0d,%0d) got=%h exp=%h", x, y, obs_pix, exp_pix);
                end
                checks++;
                if (obs_pix[11:4] !== 8'h00 || (score_3_rgb_en && score_3_rgb !== NORM_C)) begin
                    failures++; $display("FAIL scan0_only3 (%0d,%0d) got=%h", x, y, obs_pix);
                end
                if (score_3_rgb_en === 1'b1) cnt3++;
            end
        end
        checks++;
        if (cnt3 != 192) begin failures++; $display("FAIL glyph0_pixels got=%0d exp=192", cnt3); end
    endtask

    task automatic test_carry();
        int cnt2;
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            checks++;
            if (score !== to_bcd(m_score)) begin
                failures++; $display("FAIL inc_score got=%h exp=%h", score, to_bcd(m_score));
            end
        end
        checks++;
        if (score !== 12'h009) begin failures++; $display("FAIL score_009 got=%h exp=009", score); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        checks++;
        if (score !== 12'h010) begin failures++; $display("FAIL carry_010 got=%h exp=010", score); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        cnt2 = 0;
        for (int y = 16; y < 36; y++) begin
            for (int x = 32; x < 44; x++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, x, y);
                checks++;
                if (obs_pix !== exp_pix) begin
                    failures++; $display("FAIL scan10 (%0d,%0d) got=%h exp=%h", x, y, obs_pix, exp_pix);
                end
                if (score_2_rgb_en === 1'b1) cnt2++;
            end
        end
        checks++;
        if (cnt2 != 128) begin failures++; $display("FAIL glyph1_pixels got=%0d exp=128", cnt2); end
    endtask

    task automatic test_saturate();
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 1005; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            checks++;
            if (score !== to_bcd(m_score) || score_sat !== (m_score == 999)) begin
                failures++;
                $display("FAIL sat_run got=%h/%b exp=%h/%b", score, score_sat, to_bcd(m_score), m_score == 999);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            checks++;
            if (score !== 12'h999 || score_sat !== 1'b1) begin
                failures++; $display("FAIL sat_hold got=%h/%b exp=999/1", score, score_sat);
            end
        end
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        checks++;
        if (score_sat !== 1'b0) begin failures++; $display("FAIL sat_after_clear got=%b exp=0", score_sat); end
        for (int i = 0; i < 42; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        checks++;
        if (score !== 12'h042) begin failures++; $display("FAIL score_042 got=%h exp=042", score); end
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        checks++;
        if (score !== 12'h000) begin failures++; $display("FAIL clear_prio got=%h exp=000", score); end
    endtask

    task automatic test_hilite();
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 35; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int n = 1; n <= 32; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 48, 16);
            checks++;
            if (score_3_rgb_en !== 1'b1 || score_3_rgb !== ((n <= HF) ? HI_C : NORM_C)) begin
                failures++;
                $display("FAIL hilite frame=%0d got=%b/%b exp=1/%b", n, score_3_rgb_en, score_3_rgb,
                         (n <= HF) ? HI_C : NORM_C);
            end
            checks++;
            if (obs_pix !== exp_pix) begin
                failures++; $display("FAIL hilite_pix frame=%0d got=%h exp=%h", n, obs_pix, exp_pix);
            end
        end
    endtask

    task automatic test_latency_tearing();
        int cnt3;
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        pixel_x = 10'd16; pixel_y = 10'd16;
        #3;
        checks++;
        if (score_1_rgb_en !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", score_1_rgb_en); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 16, 16);
        checks++;
        if (score_1_rgb_en !== 1'b1 || obs_pix !== exp_pix) begin
            failures++; $display("FAIL lat_one got=%h exp=%h", obs_pix, exp_pix);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (score_1_rgb_en !== 1'b0) begin failures++; $display("FAIL lat_off got=%b exp=0", score_1_rgb_en); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            cnt3 = 0;
            for (int y = 16; y < 36; y++) begin
                for (int x = 48; x < 60; x++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0, x, y);
                    checks++;
                    if (obs_pix !== exp_pix) begin
                        failures++; $display("FAIL tear%0d (%0d,%0d) got=%h exp=%h", pass, x, y, obs_pix, exp_pix);
                    end
                    if (score_3_rgb_en === 1'b1) cnt3++;
                end
            end
            checks++;
            if (cnt3 != ((pass == 0) ? 192 : 128)) begin
                failures++; $display("FAIL tear_count%0d got=%0d exp=%0d", pass, cnt3, (pass == 0) ? 192 : 128);
            end
        end
    endtask

    task automatic test_random();
        bit fs, inc, clr, r;
        for (int i = 0; i < 4000; i++) begin
            fs  = ($urandom_range(49) == 0);
            inc = ($urandom_range(2) == 0);
            clr = ($urandom_range(199) == 0);
            r   = ($urandom_range(999) == 0);
            step(fs, inc, clr, r, int'($urandom_range(79)), int'($urandom_range(47)));
            checks++;
            if (obs_pix !== exp_pix || score !== to_bcd(m_score) || score_sat !== (m_score == 999)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i, obs_pix, score, score_sat,
                         exp_pix, to_bcd(m_score), m_score == 999);
            end
            if ((obs_pix[11] + obs_pix[7] + obs_pix[3]) > 1) begin
                failures++; $display("FAIL overlap cyc=%0d got=%h", i, obs_pix);
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; score_inc = 1'b0; score_clear = 1'b0;
        pixel_x = '0; pixel_y = '0;
        #1;
        test_reset();
        test_carry();
        test_saturate();
        test_clear_priority();
        test_hilite();
        test_latency_tearing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
